// File: rtl/sensor_channel_scanner.sv
// Sensor channel scanner: time-multiplexes NUM_CH sensor inputs onto one sampled stream.
// Latency: DWELL edges from entering DWELL to out_valid; one extra edge out of IDLE.
// Backpressure: a captured sample is held stable until out_ready is seen with out_valid.
module sensor_channel_scanner #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int DWELL  = 16,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         man_sel,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    // Counter only has to reach DWELL-1; keep at least one bit for DWELL == 1.
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   cur_ch;
    logic [CNT_W-1:0]   cnt;

    logic [SEL_W-1:0]   at_idx;
    logic               at_found;
    logic [SEL_W-1:0]   nx_idx;
    logic               nx_found;
    logic               man_ok;
    logic [DATA_W-1:0]  sel_data;
    logic               accept;

    // Channel index base+k reduced modulo NUM_CH (NUM_CH need not be a power of two).
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % NUM_CH;
        return SEL_W'(s);
    endfunction

    // Round-robin search: first enabled channel at/after cur_ch, and strictly after cur_ch.
    // Scanning offsets from high to low lets the nearest enabled channel win.
    // The "after" search includes offset NUM_CH so a lone enabled channel picks itself again.
    always_comb begin
        at_found = 1'b0;
        at_idx   = '0;
        nx_found = 1'b0;
        nx_idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ch_en[wrap_add(cur_ch, k)]) begin
                at_found = 1'b1;
                at_idx   = wrap_add(cur_ch, k);
            end
        end
        for (int k = NUM_CH; k >= 1; k--) begin
            if (ch_en[wrap_add(cur_ch, k)]) begin
                nx_found = 1'b1;
                nx_idx   = wrap_add(cur_ch, k);
            end
        end
    end

    // Manual selection is only honoured for an index that names a real channel.
    always_comb begin
        man_ok = (int'(man_sel) < NUM_CH);
    end

    // Slice of ch_data belonging to the currently selected channel.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cur_ch == SEL_W'(i)) begin
                sel_data = ch_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Downstream has taken the presented sample.
    always_comb begin
        accept = out_valid && out_ready;
    end

    // Scanner FSM: choose channel, dwell, capture, then hold until accepted.
    // mode/man_sel/ch_en are only looked at when a channel is being chosen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cur_ch    <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!mode) begin
                        if (at_found) begin
                            cur_ch <= at_idx;
                            cnt    <= '0;
                            state  <= ST_DWELL;
                        end
                    end else if (man_ok) begin
                        cur_ch <= man_sel;
                        cnt    <= '0;
                        state  <= ST_DWELL;
                    end
                end

                ST_DWELL: begin
                    if (cnt == CNT_LAST) begin
                        out_data  <= sel_data;
                        out_ch    <= cur_ch;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_HOLD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_HOLD: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        if (!mode) begin
                            if (nx_found) begin
                                cur_ch <= nx_idx;
                                cnt    <= '0;
                                state  <= ST_DWELL;
                            end else begin
                                // Nothing enabled: park one past the last channel so the
                                // next search from IDLE continues the rotation.
                                cur_ch <= wrap_add(cur_ch, 1);
                                state  <= ST_IDLE;
                            end
                        end else if (man_ok) begin
                            cur_ch <= man_sel;
                            cnt    <= '0;
                            state  <= ST_DWELL;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
